gf2m_mul_digit_hs: RTL

// Parametrised digit-serial GF(2^m) multiplier with optional multiply-accumulate:
// c(x) = a(x)*b(x) [+ acc(x)] mod f(x), f = x^WIDTH + x^K3 + x^K2 + x^K1 + 1 (or trinomial).

---
 rtl/gf2m_mul_digit_hs.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gf2m_mul_digit_hs.sv
// Digit-serial GF(2^m) multiplier with optional accumulate and valid/ready handshakes.
// c(x) = a(x)*b(x) [+ acc(x)] mod f(x), with f a pentanomial or a trinomial.
// a(x) is consumed D coefficients per cycle, most significant digit first (Horner form).
module gf2m_mul_digit_hs #(
  parameter int WIDTH = 101,
  parameter int K3    = 7,
  parameter int K2    = 6,
  parameter int K1    = 1,
  parameter int D     = 16,
  parameter int PENTA = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_c,
  output logic             busy
);

  localparam int NDIG = (WIDTH + D - 1) / D;
  localparam int PADW = NDIG * D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reduction taps of f without the leading x^WIDTH term: x^WIDTH == TAPS (mod f).
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TAPS = ONE | (ONE << K1) |
                                      ((PENTA != 0) ? ((ONE << K2) | (ONE << K3)) : '0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [PADW-1:0]  r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_acc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [PADW-1:0]  w_a_pad;
  logic [D-1:0]     w_digit;
  logic [D-1:0]     w_hi;
  logic [WIDTH-1:0] w_hi_ext;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_cx;
  logic [WIDTH-1:0] w_c_step;
  logic [WIDTH-1:0] w_bx [0:D-1];
  logic [WIDTH-1:0] w_pp [0:D];

  // Zero padding goes above the MSB so every coefficient keeps its weight.
  generate
    if (PADW > WIDTH) begin : g_pad
      assign w_a_pad = {{(PADW-WIDTH){1'b0}}, op_a};
    end else begin : g_nopad
      assign w_a_pad = op_a;
    end
  endgenerate

  assign w_digit = r_a[PADW-1 -: D];
  assign w_last  = (r_cnt == CW'(NDIG - 1));

  // b*x^k mod f for k = 0..D-1, each one a single multiply-by-x step of the previous.
  assign w_bx[0] = r_b;
  generate
    for (genvar gi = 1; gi < D; gi++) begin : g_bx
      assign w_bx[gi] = {w_bx[gi-1][WIDTH-2:0], 1'b0} ^
                        (w_bx[gi-1][WIDTH-1] ? TAPS : '0);
    end
  endgenerate

  // digit*b mod f as the XOR of the selected b*x^k terms (digit bit k has weight x^k).
  assign w_pp[0] = '0;
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_pp
      assign w_pp[gi+1] = w_pp[gi] ^ ({WIDTH{w_digit[gi]}} & w_bx[gi]);
    end
  endgenerate

  // c*x^D mod f: the D bits shifted past x^(WIDTH-1) are folded back once through the taps.
  // D <= WIDTH-K3 (or WIDTH-K1) keeps the folded bits below x^WIDTH, so one fold suffices.
  assign w_hi     = r_c[WIDTH-1 -: D];
  assign w_hi_ext = {{(WIDTH-D){1'b0}}, w_hi};
  assign w_lo     = r_c << D;
  assign w_cx     = w_lo ^ w_hi_ext ^ (w_hi_ext << K1) ^
                    ((PENTA != 0) ? ((w_hi_ext << K2) ^ (w_hi_ext << K3)) : '0);
  assign w_c_step = w_cx ^ w_pp[D];

  // Next-state and datapath control decode.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register plus registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

  // Operand capture on accept, then one Horner step per RUN cycle; acc is added on the last.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= w_a_pad;
      r_b   <= op_b;
      r_acc <= mode ? acc_in : '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a <= r_a << D;
      if (w_last) begin
        r_c   <= w_c_step ^ r_acc;
        r_cnt <= '0;
      end else begin
        r_c   <= w_c_step;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign op_c      = r_c;

endmodule
